// File: rtl/aes_mixcol_seq.sv
// AES MixColumns sequencer: one shared column mixer, one column per clock, with final-round bypass.
// Optional macro INV_MIX_EN adds in_inv to select the InvMixColumns coefficients.
module aes_mixcol_seq #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_data,
    input  logic             in_last,
    input  logic [TAG_W-1:0] in_tag,
`ifdef INV_MIX_EN
    input  logic             in_inv,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy,
    output logic [1:0]       o_dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid && ready; a block
    // is taken only in IDLE and the result is held unchanged in DONE until taken.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MIX  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       r_col_cnt;
    logic [127:0]     r_data;
    logic [127:0]     r_out_data;
    logic [TAG_W-1:0] r_out_tag;
    logic             r_out_valid;
    logic             r_inv;
    logic [31:0]      w_col;
    logic [31:0]      w_fwd;
    logic [31:0]      w_mixed;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_fwd(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

`ifdef INV_MIX_EN
    logic [31:0] w_inv;

    // Multiples 9/b/d/e from the x2, x4, x8 chain of xtime stages.
    function automatic logic [31:0] mix_inv(input logic [31:0] c);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        logic [31:0] res;
        for (int j = 0; j < 4; j++) begin
            a[j]  = c[31-8*j -: 8];
            x2    = xtime(a[j]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[j] = x8 ^ a[j];
            mb[j] = x8 ^ x2 ^ a[j];
            md[j] = x8 ^ x4 ^ a[j];
            me[j] = x8 ^ x4 ^ x2;
        end
        res = 32'd0;
        for (int i = 0; i < 4; i++) begin
            res[31-8*i -: 8] = me[i] ^ mb[(i+1)%4] ^ md[(i+2)%4] ^ m9[(i+3)%4];
        end
        return res;
    endfunction
`endif

    always_comb begin
        w_col = r_data[127:96];
        case (r_col_cnt)
            2'd0:    w_col = r_data[127:96];
            2'd1:    w_col = r_data[95:64];
            2'd2:    w_col = r_data[63:32];
            default: w_col = r_data[31:0];
        endcase
    end

    assign w_fwd = mix_fwd(w_col);
`ifdef INV_MIX_EN
    assign w_inv   = mix_inv(w_col);
    assign w_mixed = r_inv ? w_inv : w_fwd;
`else
    assign w_mixed = w_fwd;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_col_cnt   <= 2'd0;
            r_data      <= 128'd0;
            r_out_data  <= 128'd0;
            r_out_tag   <= '0;
            r_out_valid <= 1'b0;
            r_inv       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_out_tag <= in_tag;
                        if (in_last) begin
                            r_out_data  <= in_data;
                            r_out_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end else begin
                            r_data    <= in_data;
`ifdef INV_MIX_EN
                            r_inv     <= in_inv;
`else
                            r_inv     <= 1'b0;
`endif
                            r_col_cnt <= 2'd0;
                            r_state   <= ST_MIX;
                        end
                    end
                end
                ST_MIX: begin
                    case (r_col_cnt)
                        2'd0:    r_out_data[127:96] <= w_mixed;
                        2'd1:    r_out_data[95:64]  <= w_mixed;
                        2'd2:    r_out_data[63:32]  <= w_mixed;
                        default: r_out_data[31:0]   <= w_mixed;
                    endcase
                    if (r_col_cnt == 2'd3) begin
                        r_col_cnt   <= 2'd0;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_col_cnt <= r_col_cnt + 2'd1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready    = (r_state == ST_IDLE);
    assign busy        = (r_state == ST_MIX) || (r_state == ST_DONE);
    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign out_tag     = r_out_tag;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_aes_mixcol_seq.sv
// Directed bench for aes_mixcol_seq: GF(2^8) reference model, scoreboard queue and literal vectors.
module tb_aes_mixcol_seq;

    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [127:0]     in_data = '0;
    logic             in_last = 1'b0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             in_inv = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [127:0]     out_data;
    logic [TAG_W-1:0] out_tag;
    logic             busy;
    logic [1:0]       dbg_state;

    int checks = 0;
    int errors = 0;
    logic [TAG_W+127:0] exp_q[$];

    aes_mixcol_seq #(.TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .in_tag(in_tag),
`ifdef INV_MIX_EN
        .in_inv(in_inv),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .busy(busy), .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (generic GF(2^8) multiply) ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'd0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [31:0] model_col(input logic [31:0] col, input logic inv);
        logic [7:0] coef [4];
        logic [7:0] a [4];
        logic [7:0] r;
        logic [31:0] res;
        if (inv) begin
            coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        end else begin
            coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
        end
        for (int j = 0; j < 4; j++) a[j] = col[31-8*j -: 8];
        res = 32'd0;
        for (int i = 0; i < 4; i++) begin
            r = 8'd0;
            for (int j = 0; j < 4; j++) r = r ^ gmul(coef[(j - i + 4) % 4], a[j]);
            res[31-8*i -: 8] = r;
        end
        return res;
    endfunction

    function automatic logic [127:0] model_state(input logic [127:0] d, input logic last, input logic inv);
        logic [127:0] res;
        if (last) return d;
        res = '0;
        for (int c = 0; c < 4; c++) res[127-32*c -: 32] = model_col(d[127-32*c -: 32], inv);
        return res;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] d, input logic last, input logic [TAG_W-1:0] tag,
                        input logic inv);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("send_ready_timeout", {127'd0, in_ready}, 128'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        in_tag   = tag;
        in_inv   = inv;
        exp_q.push_back({tag, model_state(d, last, inv)});
        tick();
        in_valid = 1'b0;
        in_data  = ~d;
        in_last  = ~last;
        in_inv   = ~inv;
    endtask

    task automatic wait_valid(output int edges);
        edges = 0;
        while (!out_valid && edges < 50) begin
            tick();
            edges++;
        end
        chk("out_valid_timeout", {127'd0, out_valid}, 128'd1);
    endtask

    // ---------------- compare process ----------------
    logic               prev_hold = 1'b0;
    logic [127:0]       prev_data;
    logic [TAG_W-1:0]   prev_tag;
    logic [TAG_W+127:0] exp_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_data", out_data, prev_data);
                chk("hold_tag", {124'd0, out_tag}, {124'd0, prev_tag});
            end
            if (out_valid) begin
                chk("in_ready_while_valid", {127'd0, in_ready}, 128'd0);
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_output", {127'd0, out_valid}, 128'd0);
                    end else begin
                        exp_e = exp_q.pop_front();
                        chk("sb_data", out_data, exp_e[127:0]);
                        chk("sb_tag", {124'd0, out_tag}, {124'd0, exp_e[TAG_W+127:128]});
                    end
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
            prev_tag  = out_tag;
        end
    end

    // ---------------- directed sequence ----------------
    localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
    localparam logic [127:0] FIPS_OUT = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
    localparam logic [127:0] COL_IN   = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
    localparam logic [127:0] COL_OUT  = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
    localparam logic [127:0] BYP      = 128'h00112233_44556677_8899aabb_ccddeeff;

    initial begin
        int e;
        logic [127:0] rnd;
        logic [127:0] mid;

        // Pin the model against literal vectors before trusting it.
        chk("model_fips", model_state(FIPS_IN, 1'b0, 1'b0), FIPS_OUT);
        chk("model_cols", model_state(COL_IN, 1'b0, 1'b0), COL_OUT);
        chk("model_inv", model_state(FIPS_OUT, 1'b0, 1'b1), FIPS_IN);

        // Reset state
        repeat (3) tick();
        chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
        chk("rst_busy", {127'd0, busy}, 128'd0);
        chk("rst_out_data", out_data, 128'd0);
        chk("rst_state", {126'd0, dbg_state}, 128'd0);
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready", {127'd0, in_ready}, 128'd1);

        // Reset in the middle of MIX aborts the block
        send(COL_IN, 1'b0, 4'd3, 1'b0);
        tick();
        tick();
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("abort_out_valid", {127'd0, out_valid}, 128'd0);
        chk("abort_busy", {127'd0, busy}, 128'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("abort_in_ready", {127'd0, in_ready}, 128'd1);
        chk("abort_out_data", out_data, 128'd0);

        // FIPS-197 vector
        out_ready = 1'b1;
        send(FIPS_IN, 1'b0, 4'd5, 1'b0);
        wait_valid(e);
        chk("fips_latency", 128'(e), 128'd4);
        chk("fips_data", out_data, FIPS_OUT);
        chk("fips_tag", {124'd0, out_tag}, 128'd5);
        tick();
        chk("fips_valid_one_cycle", {127'd0, out_valid}, 128'd0);

        // Per-column vectors
        send(COL_IN, 1'b0, 4'd9, 1'b0);
        wait_valid(e);
        chk("cols_latency", 128'(e), 128'd4);
        chk("cols_data", out_data, COL_OUT);
        tick();

        // Final-round bypass
        send(BYP, 1'b1, 4'd2, 1'b0);
        wait_valid(e);
        chk("byp_latency", 128'(e), 128'd0);
        chk("byp_data", out_data, BYP);
        chk("byp_tag", {124'd0, out_tag}, 128'd2);
        tick();

        // Backpressure in DONE while a new block is offered
        out_ready = 1'b0;
        send(FIPS_IN, 1'b0, 4'd6, 1'b0);
        wait_valid(e);
        in_valid = 1'b1;
        in_data  = COL_IN;
        in_last  = 1'b0;
        in_tag   = 4'd7;
        in_inv   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("bp_in_ready", {127'd0, in_ready}, 128'd0);
            chk("bp_data", out_data, FIPS_OUT);
            chk("bp_tag", {124'd0, out_tag}, 128'd6);
            tick();
        end
        out_ready = 1'b1;
        exp_q.push_back({4'd7, model_state(COL_IN, 1'b0, 1'b0)});
        tick();
        chk("bp_release_valid", {127'd0, out_valid}, 128'd0);
        chk("bp_release_ready", {127'd0, in_ready}, 128'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_next_busy", {127'd0, busy}, 128'd1);
        chk("bp_next_in_ready", {127'd0, in_ready}, 128'd0);
        wait_valid(e);
        chk("bp_next_latency", 128'(e), 128'd4);
        chk("bp_next_data", out_data, COL_OUT);
        tick();

        // Back-to-back blocks, one of them a bypass
        for (int i = 0; i < 5; i++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom};
            send(rnd, (i == 2), 4'(i + 10), 1'b0);
        end

`ifdef INV_MIX_EN
        send(FIPS_OUT, 1'b0, 4'd1, 1'b1);
        wait_valid(e);
        chk("inv_latency", 128'(e), 128'd4);
        chk("inv_data", out_data, FIPS_IN);
        tick();
        rnd = {$urandom, $urandom, $urandom, $urandom};
        send(rnd, 1'b0, 4'd2, 1'b0);
        wait_valid(e);
        mid = out_data;
        tick();
        send(mid, 1'b0, 4'd3, 1'b1);
        wait_valid(e);
        chk("inv_roundtrip", out_data, rnd);
        tick();
        send(BYP, 1'b1, 4'd4, 1'b1);
        wait_valid(e);
        chk("inv_bypass", out_data, BYP);
        tick();
`else
        mid = '0;
`endif

        e = 0;
        while (exp_q.size() != 0 && e < 200) begin
            tick();
            e++;
        end
        chk("drain_queue", 128'(exp_q.size()), 128'd0);
        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
